// File: rtl/btn_tick_gen.sv
// btn_tick_gen: conditions two raw push-buttons into single-cycle step pulses.
//
// Each button is passed through a 2-flop synchroniser, debounced by a small
// per-channel FSM, and turned into tick requests with hold-to-repeat. A
// shared arbiter guarantees tick_r and tick_l never fire in the same cycle.
//
// Ports:
//   clk     in   system clock
//   rst     in   synchronous active-high reset
//   btn_r   in   raw right button (asynchronous, active-high)
//   btn_l   in   raw left button (asynchronous, active-high)
//   tick_r  out  one-cycle pulse, step right
//   tick_l  out  one-cycle pulse, step left
//   held_r  out  right channel in HELD / REPEAT / RELEASE_WAIT
//   held_l  out  left channel in HELD / REPEAT / RELEASE_WAIT

// One button channel: synchroniser + debounce/repeat FSM.
// req is a combinational one-cycle request; held decodes the state register.
module btn_tick_chan #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_RATE     = 10_000_000,
    parameter int REPEAT_EN       = 1,
    parameter int CW              = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic req,
    output logic held
);
    typedef enum logic [2:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        REPEAT,
        RELEASE_WAIT
    } state_t;

    // Terminal counts: the counter reaching N means N qualifying cycles seen.
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RATE_LAST = CW'(REPEAT_RATE - 1);
    localparam logic [CW-1:0] ONE = CW'(1);

    logic [1:0]    sync;
    logic          s;
    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;

    assign s = sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= 2'b00;
            state <= IDLE;
            cnt   <= '0;
        end else begin
            sync  <= {sync[0], btn};
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        req      = 1'b0;
        case (state)
            IDLE: begin
                if (s) begin
                    cnt_nx   = '0;
                    state_nx = PRESS_WAIT;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end else if (cnt == DEB_LAST) begin
                    req      = 1'b1;
                    cnt_nx   = '0;
                    state_nx = HELD;
                end else begin
                    cnt_nx = cnt + ONE;
                end
            end
            HELD: begin
                if (!s) begin
                    cnt_nx   = '0;
                    state_nx = RELEASE_WAIT;
                end else if (REPEAT_EN != 0) begin
                    if (cnt == DLY_LAST) begin
                        req      = 1'b1;
                        cnt_nx   = '0;
                        state_nx = REPEAT;
                    end else begin
                        cnt_nx = cnt + ONE;
                    end
                end
                // with repeat disabled the counter stays frozen while held
            end
            REPEAT: begin
                if (!s) begin
                    cnt_nx   = '0;
                    state_nx = RELEASE_WAIT;
                end else if (cnt == RATE_LAST) begin
                    req    = 1'b1;
                    cnt_nx = '0;
                end else begin
                    cnt_nx = cnt + ONE;
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    // bounce on release: back to HELD, repeat delay restarts
                    cnt_nx   = '0;
                    state_nx = HELD;
                end else if (cnt == DEB_LAST) begin
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + ONE;
                end
            end
            default: begin
                cnt_nx   = '0;
                state_nx = IDLE;
            end
        endcase
    end

    assign held = (state == HELD) || (state == REPEAT) || (state == RELEASE_WAIT);
endmodule

module btn_tick_gen #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_RATE     = 10_000_000,
    parameter int REPEAT_EN       = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_r,
    input  logic btn_l,
    output logic tick_r,
    output logic tick_l,
    output logic held_r,
    output logic held_l
);
    localparam int MAX_AB = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_P  = (MAX_AB > REPEAT_RATE) ? MAX_AB : REPEAT_RATE;
    localparam int CW     = $clog2(MAX_P) + 1;

    // channel 0 = right, channel 1 = left
    logic [1:0] btn_v, req, held;
    logic       pend_r, pend_l;

    assign btn_v = {btn_l, btn_r};

    for (genvar i = 0; i < 2; i++) begin : g_chan
        btn_tick_chan #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_RATE    (REPEAT_RATE),
            .REPEAT_EN      (REPEAT_EN),
            .CW             (CW)
        ) u_chan (
            .clk (clk),
            .rst (rst),
            .btn (btn_v[i]),
            .req (req[i]),
            .held(held[i])
        );
    end

    assign held_r = held[0];
    assign held_l = held[1];

    // One tick slot per cycle. A pending tick always wins over a fresh
    // request; a fresh request of the same side merges into the pending one.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_r <= 1'b0;
            tick_l <= 1'b0;
            pend_r <= 1'b0;
            pend_l <= 1'b0;
        end else if (pend_l) begin
            tick_l <= 1'b1;
            tick_r <= 1'b0;
            pend_l <= 1'b0;
            pend_r <= req[0];
        end else if (pend_r) begin
            tick_r <= 1'b1;
            tick_l <= 1'b0;
            pend_r <= 1'b0;
            pend_l <= req[1];
        end else begin
            tick_r <= req[0];
            tick_l <= req[1] & ~req[0];
            pend_r <= 1'b0;
            pend_l <= req[1] & req[0];
        end
    end
endmodule

// File: tb/tb_btn_tick_gen.sv
// tb_btn_tick_gen: directed scenarios plus randomized button traffic for
// btn_tick_gen, checked cycle by cycle against a run-length reference model.
module tb_btn_tick_gen;
    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RR = 3;

    logic clk = 1'b0;
    logic rst, btn_r, btn_l;
    logic tick_r, tick_l, held_r, held_l;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    btn_tick_gen #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR),
        .REPEAT_EN      (1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .btn_r (btn_r),
        .btn_l (btn_l),
        .tick_r(tick_r),
        .tick_l(tick_l),
        .held_r(held_r),
        .held_l(held_l)
    );

    // ---------------- reference model ----------------
    // Each button is seen two edges late. A press is accepted once the
    // delayed level has been 1 for D+1 consecutive edges while released, a
    // release once it has been 0 for D+1 edges while pressed. While pressed,
    // ticks are due at fixed times: RD after the press (or after a bounce
    // back to 1), then every RR.
    logic [1:0] sp [2];
    logic       lastv [2];
    int         run [2];
    bit         pressed [2];
    int         next_t [2];
    int         ecount = 0;
    bit         m_pend_r, m_pend_l;
    logic       exp_tr, exp_tl;

    task automatic model_step(input logic br, input logic bl, input logic rs);
        logic [1:0] rq;
        logic want_r, want_l;
        rq = 2'b00;
        if (rs) begin
            for (int c = 0; c < 2; c++) begin
                sp[c] = 2'b00; lastv[c] = 1'b0; run[c] = 0; pressed[c] = 0;
            end
            m_pend_r = 0; m_pend_l = 0; exp_tr = 0; exp_tl = 0;
            ecount++;
            return;
        end
        for (int c = 0; c < 2; c++) begin
            logic v, pv;
            v  = sp[c][1];
            pv = lastv[c];
            sp[c] = {sp[c][0], (c == 0) ? br : bl};
            run[c] = (v == pv) ? run[c] + 1 : 1;
            lastv[c] = v;
            if (!pressed[c]) begin
                if (v && run[c] == D + 1) begin
                    rq[c] = 1'b1; pressed[c] = 1; next_t[c] = ecount + RD;
                end
            end else if (!v) begin
                if (run[c] == D + 1) pressed[c] = 0;
            end else if (!pv) begin
                next_t[c] = ecount + RD;
            end else if (ecount == next_t[c]) begin
                rq[c] = 1'b1; next_t[c] = ecount + RR;
            end
        end
        want_r = rq[0] | m_pend_r;
        want_l = rq[1] | m_pend_l;
        exp_tr = 0; exp_tl = 0;
        if (want_r && want_l) begin
            if (m_pend_l) begin exp_tl = 1; m_pend_l = 0; m_pend_r = 1; end
            else begin exp_tr = 1; m_pend_r = 0; m_pend_l = 1; end
        end else if (want_r) begin
            exp_tr = 1; m_pend_r = 0;
        end else if (want_l) begin
            exp_tl = 1; m_pend_l = 0;
        end
        ecount++;
    endtask

    function automatic logic [3:0] exp_o();
        return {exp_tr, exp_tl, pressed[0] ? 1'b1 : 1'b0, pressed[1] ? 1'b1 : 1'b0};
    endfunction

    // Drive one cycle: inputs change at the falling edge, DUT and model
    // both sample them at the next rising edge, outputs read at the fall.
    task automatic cycle(input logic br, input logic bl, input logic rs);
        btn_r = br; btn_l = bl; rst = rs;
        @(posedge clk);
        model_step(br, bl, rs);
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        btn_r = 1'b1; btn_l = 1'b1; rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 14; i++) begin
            cycle(1'b1, 1'b1, 1'b1);
            checks++;
            if ({tick_r, tick_l, held_r, held_l} !== 4'b0000) begin
                failures++;
                $display("FAIL reset cyc=%0d outs=%b required=0000", i, {tick_r, tick_l, held_r, held_l});
            end
        end
        drain(12);
    endtask

    task automatic test_clean_press();
        int first = -1, nr = 0, nl = 0;
        cyc = 0;
        for (int i = 0; i < 24; i++) begin
            cycle(i < 8, 1'b0, 1'b0);
            checks++;
            if ({tick_r, tick_l, held_r, held_l} !== exp_o()) begin
                failures++;
                $display("FAIL clean_press_model cyc=%0d outs=%b required=%b", cyc, {tick_r, tick_l, held_r, held_l}, exp_o());
            end
            if (tick_r) begin nr++; if (first < 0) first = cyc; end
            if (tick_l) nl++;
            if (cyc == 7) begin
                checks++;
                if (held_r !== 1'b1) begin failures++; $display("FAIL clean_press_held cyc=7 held_r=%b required=1", held_r); end
            end
        end
        checks++;
        if (first != 7 || nr != 1 || nl != 0) begin
            failures++;
            $display("FAIL clean_press first=%0d n_r=%0d n_l=%0d required 7/1/0", first, nr, nl);
        end
    endtask

    task automatic test_bounce();
        int first = -1, nl = 0;
        logic pat [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        cyc = 0;
        for (int i = 0; i < 28; i++) begin
            cycle(1'b0, (i < 4) ? pat[i] : (i < 14), 1'b0);
            checks++;
            if ({tick_r, tick_l, held_r, held_l} !== exp_o()) begin
                failures++;
                $display("FAIL bounce_model cyc=%0d outs=%b required=%b", cyc, {tick_r, tick_l, held_r, held_l}, exp_o());
            end
            if (tick_l) begin nl++; if (first < 0) first = cyc; end
        end
        // final rise is in cycle 4
        checks++;
        if (first != 4 + 7 || nl != 1) begin
            failures++;
            $display("FAIL bounce first_tick=%0d n=%0d required 11/1", first, nl);
        end
    endtask

    task automatic test_auto_repeat();
        int got [$];
        int want [$] = '{7, 17, 20, 23, 26, 29};
        bit wide = 0;
        logic prev = 1'b0;
        cyc = 0;
        for (int i = 0; i < 44; i++) begin
            cycle(i < 30, 1'b0, 1'b0);
            checks++;
            if ({tick_r, tick_l, held_r, held_l} !== exp_o()) begin
                failures++;
                $display("FAIL repeat_model cyc=%0d outs=%b required=%b", cyc, {tick_r, tick_l, held_r, held_l}, exp_o());
            end
            if (tick_r && cyc < 30) got.push_back(cyc);
            if (tick_r && prev) wide = 1;
            prev = tick_r;
        end
        checks++;
        if (got != want || wide) begin
            failures++;
            $display("FAIL repeat ticks=%p wide=%0d required %p wide=0", got, wide, want);
        end
    endtask

    task automatic test_release_glitch();
        int nmid = 0, after = -1;
        bit dropped = 0;
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            cycle((i < 10) || (i >= 12 && i < 26), 1'b0, 1'b0);
            checks++;
            if ({tick_r, tick_l, held_r, held_l} !== exp_o()) begin
                failures++;
                $display("FAIL glitch_model cyc=%0d outs=%b required=%b", cyc, {tick_r, tick_l, held_r, held_l}, exp_o());
            end
            if (tick_r && cyc > 7 && cyc < 25) nmid++;
            if (tick_r && cyc >= 25 && after < 0) after = cyc;
            if (cyc >= 7 && cyc <= 26 && held_r !== 1'b1) dropped = 1;
        end
        // low seen at edges 13,14; HELD re-entered at edge 15; tick 10 later
        checks++;
        if (nmid != 0 || after != 25 || dropped) begin
            failures++;
            $display("FAIL glitch mid_ticks=%0d next=%0d held_dropped=%0d required 0/25/0", nmid, after, dropped);
        end
    endtask

    task automatic test_simultaneous();
        int fr = -1, fl = -1, both = 0;
        cyc = 0;
        for (int i = 0; i < 34; i++) begin
            cycle(i < 22, i < 22, 1'b0);
            checks++;
            if ({tick_r, tick_l, held_r, held_l} !== exp_o()) begin
                failures++;
                $display("FAIL simul_model cyc=%0d outs=%b required=%b", cyc, {tick_r, tick_l, held_r, held_l}, exp_o());
            end
            if (tick_r && fr < 0) fr = cyc;
            if (tick_l && fl < 0) fl = cyc;
            if (tick_r && tick_l) both++;
        end
        checks++;
        if (fr != 7 || fl != 8 || both != 0) begin
            failures++;
            $display("FAIL simultaneous r=%0d l=%0d overlap=%0d required 7/8/0", fr, fl, both);
        end
    endtask

    task automatic test_reset_while_held();
        int nxt = -1;
        cyc = 0;
        for (int i = 0; i < 34; i++) begin
            cycle(1'b1, 1'b0, i == 22);
            checks++;
            if ({tick_r, tick_l, held_r, held_l} !== exp_o()) begin
                failures++;
                $display("FAIL rst_held_model cyc=%0d outs=%b required=%b", cyc, {tick_r, tick_l, held_r, held_l}, exp_o());
            end
            if (cyc == 23) begin
                checks++;
                if ({tick_r, tick_l, held_r, held_l} !== 4'b0000) begin
                    failures++;
                    $display("FAIL rst_held_clear outs=%b required=0000", {tick_r, tick_l, held_r, held_l});
                end
            end
            if (tick_r && cyc > 23 && nxt < 0) nxt = cyc;
        end
        checks++;
        if (nxt != 23 + 2 + 4 + 1) begin
            failures++;
            $display("FAIL rst_held next_tick=%0d required=%0d", nxt, 30);
        end
        drain(14);
    endtask

    task automatic test_random();
        logic lvl [2];
        int rem [2];
        int nt = 0;
        lvl[0] = 0; lvl[1] = 0; rem[0] = 0; rem[1] = 0;
        cyc = 0;
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < 2; c++) begin
                if (rem[c] == 0) begin
                    lvl[c] = ~lvl[c];
                    rem[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 45) : $urandom_range(1, 8);
                end
                rem[c]--;
            end
            cycle(lvl[0], lvl[1], $urandom_range(0, 399) == 0);
            checks++;
            if ({tick_r, tick_l, held_r, held_l} !== exp_o()) begin
                failures++;
                $display("FAIL random_model cyc=%0d outs=%b required=%b", cyc, {tick_r, tick_l, held_r, held_l}, exp_o());
            end
            if (tick_r | tick_l) nt++;
        end
        checks++;
        if (nt == 0) begin
            failures++;
            $display("FAIL random_activity ticks=%0d required>0", nt);
        end
        drain(14);
    endtask

    initial begin
        btn_r = 1'b0; btn_l = 1'b0; rst = 1'b1;
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_release_glitch();
        test_simultaneous();
        test_reset_while_held();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
